// File: rtl/frame_transmitter.sv
// frame_transmitter: serializes eight 24-bit GRB LED frames MSB-first, one bit
// per new_bit_rqst, and asks upstream for a fresh frame set after LED 7.
module frame_transmitter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        new_frame_rqst,
    input  logic        new_bit_rqst,
    input  logic [23:0] frame_for_led0,
    input  logic [23:0] frame_for_led1,
    input  logic [23:0] frame_for_led2,
    input  logic [23:0] frame_for_led3,
    input  logic [23:0] frame_for_led4,
    input  logic [23:0] frame_for_led5,
    input  logic [23:0] frame_for_led6,
    input  logic [23:0] frame_for_led7,
    output logic        all_bits_shifted,
    output logic        bit_to_transmit,
    output logic        new_frames_set_rqst,
    output logic [23:0] frame_to_transmit_dbg,
    output logic [2:0]  no_of_frame_dbg
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned LED_N   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 5;

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               done_q,  done_d;
    logic               wrap_q,  wrap_d;
    logic [FRAME_W-1:0] frame_sel;

    // Pick the frame belonging to the current LED index
    always_comb begin
        frame_sel = frame_for_led0;
        case (idx_q)
            IDX_W'(1): frame_sel = frame_for_led1;
            IDX_W'(2): frame_sel = frame_for_led2;
            IDX_W'(3): frame_sel = frame_for_led3;
            IDX_W'(4): frame_sel = frame_for_led4;
            IDX_W'(5): frame_sel = frame_for_led5;
            IDX_W'(6): frame_sel = frame_for_led6;
            IDX_W'(7): frame_sel = frame_for_led7;
            default:   frame_sel = frame_for_led0;
        endcase
    end

    // Next state: load beats shift; a shift with nothing left is ignored
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = done_q;
        wrap_d  = 1'b0;
        if (new_frame_rqst) begin
            shreg_d = frame_sel;
            cnt_d   = CNT_W'(FRAME_W);
            done_d  = 1'b0;
        end else if (new_bit_rqst && (cnt_q != CNT_W'(0))) begin
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                done_d = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                wrap_d = (idx_q == IDX_W'(LED_N - 1));
            end
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Outputs are direct views of registers
    assign all_bits_shifted      = done_q;
    assign bit_to_transmit       = shreg_q[FRAME_W-1];
    assign new_frames_set_rqst   = wrap_q;
    assign frame_to_transmit_dbg = shreg_q;
    assign no_of_frame_dbg       = idx_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter.
module tb_frame_transmitter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        new_frame_rqst;
    logic        new_bit_rqst;
    logic [23:0] fr [8];
    logic        all_bits_shifted;
    logic        bit_to_transmit;
    logic        new_frames_set_rqst;
    logic [23:0] frame_to_transmit_dbg;
    logic [2:0]  no_of_frame_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [23:0] tbl [8] = '{24'h111111, 24'h222222, 24'h444444, 24'h888888,
                             24'h999999, 24'hAAAAAA, 24'hCCCCCC, 24'hBBBBBB};

    always #5 clk = ~clk;

    frame_transmitter dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .new_frame_rqst        (new_frame_rqst),
        .new_bit_rqst          (new_bit_rqst),
        .frame_for_led0        (fr[0]),
        .frame_for_led1        (fr[1]),
        .frame_for_led2        (fr[2]),
        .frame_for_led3        (fr[3]),
        .frame_for_led4        (fr[4]),
        .frame_for_led5        (fr[5]),
        .frame_for_led6        (fr[6]),
        .frame_for_led7        (fr[7]),
        .all_bits_shifted      (all_bits_shifted),
        .bit_to_transmit       (bit_to_transmit),
        .new_frames_set_rqst   (new_frames_set_rqst),
        .frame_to_transmit_dbg (frame_to_transmit_dbg),
        .no_of_frame_dbg       (no_of_frame_dbg)
    );

    // All stimulus tasks start and end at a falling edge
    task automatic do_reset();
        rstn = 1'b0;
        new_frame_rqst = 1'b0;
        new_bit_rqst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_frame();
        new_frame_rqst = 1'b1;
        @(negedge clk);
        new_frame_rqst = 1'b0;
    endtask

    // Sample the presented bit, then consume it; count wrap pulses seen
    task automatic shift_bits(input int n, output logic [23:0] got, output int pulses);
        got = '0;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            got = {got[22:0], bit_to_transmit};
            new_bit_rqst = 1'b1;
            @(negedge clk);
            new_bit_rqst = 1'b0;
            if (new_frames_set_rqst) pulses++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) fr[i] = tbl[i];
        do_reset();
        total_cnt++;
        if ({all_bits_shifted, bit_to_transmit, new_frames_set_rqst} !== 3'b100) begin
            $display("FAIL reset_flags got=%b exp=100", {all_bits_shifted, bit_to_transmit, new_frames_set_rqst});
        end else pass_cnt++;
        total_cnt++;
        if (frame_to_transmit_dbg !== 24'h0 || no_of_frame_dbg !== 3'd0) begin
            $display("FAIL reset_dbg got=%h/%0d exp=000000/0", frame_to_transmit_dbg, no_of_frame_dbg);
        end else pass_cnt++;
        new_bit_rqst = 1'b1;
        repeat (5) @(negedge clk);
        new_bit_rqst = 1'b0;
        total_cnt++;
        if ({all_bits_shifted, bit_to_transmit, new_frames_set_rqst} !== 3'b100 ||
            frame_to_transmit_dbg !== 24'h0 || no_of_frame_dbg !== 3'd0) begin
            $display("FAIL idle_bit_rqst got=%b %h %0d exp=100 000000 0",
                     {all_bits_shifted, bit_to_transmit, new_frames_set_rqst}, frame_to_transmit_dbg, no_of_frame_dbg);
        end else pass_cnt++;
    endtask

    task automatic test_single_led();
        logic [23:0] exp = 24'h111111;
        int errs = 0;
        do_reset();
        fr[0] = exp;
        pulse_frame();
        total_cnt++;
        if (frame_to_transmit_dbg !== exp || all_bits_shifted !== 1'b0) begin
            $display("FAIL single_load got=%h abs=%b exp=%h abs=0", frame_to_transmit_dbg, all_bits_shifted, exp);
        end else pass_cnt++;
        for (int i = 0; i < 24; i++) begin
            logic eb;
            eb = ((i % 4) == 3);
            if (bit_to_transmit !== eb) begin
                errs++;
                $display("FAIL single_bit%0d got=%b exp=%b", i, bit_to_transmit, eb);
            end
            new_bit_rqst = 1'b1;
            @(negedge clk);
            new_bit_rqst = 1'b0;
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        total_cnt++;
        if (all_bits_shifted !== 1'b1 || no_of_frame_dbg !== 3'd1 || frame_to_transmit_dbg !== 24'h0) begin
            $display("FAIL single_done got=abs%b idx%0d %h exp=abs1 idx1 000000",
                     all_bits_shifted, no_of_frame_dbg, frame_to_transmit_dbg);
        end else pass_cnt++;
        // Extra bit requests after completion must not advance anything
        new_bit_rqst = 1'b1;
        repeat (3) @(negedge clk);
        new_bit_rqst = 1'b0;
        total_cnt++;
        if (no_of_frame_dbg !== 3'd1 || new_frames_set_rqst !== 1'b0 || all_bits_shifted !== 1'b1) begin
            $display("FAIL extra_bits got=idx%0d pulse%b abs%b exp=idx1 pulse0 abs1",
                     no_of_frame_dbg, new_frames_set_rqst, all_bits_shifted);
        end else pass_cnt++;
    endtask

    task automatic test_all_leds();
        logic [23:0] got;
        int pulses;
        int early = 0;
        do_reset();
        for (int i = 0; i < 8; i++) fr[i] = tbl[i];
        for (int led = 0; led < 8; led++) begin
            total_cnt++;
            if (no_of_frame_dbg !== 3'(led)) begin
                $display("FAIL led%0d_idx got=%0d exp=%0d", led, no_of_frame_dbg, led);
            end else pass_cnt++;
            pulse_frame();
            shift_bits(23, got, pulses);
            early += pulses;
            shift_bits(1, got, pulses);
            got = {tbl[led][23:1], got[0]};
            if (led < 7) early += pulses;
            total_cnt++;
            if (led == 7 && pulses !== 1) begin
                $display("FAIL wrap_pulse got=%0d exp=1", pulses);
            end else if (led < 7 && early !== 0) begin
                $display("FAIL early_pulse led%0d got=%0d exp=0", led, early);
            end else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (new_frames_set_rqst !== 1'b0 || no_of_frame_dbg !== 3'd0) begin
            $display("FAIL wrap_after got=pulse%b idx%0d exp=pulse0 idx0", new_frames_set_rqst, no_of_frame_dbg);
        end else pass_cnt++;
        // Serialization of every LED word, checked as a whole
        do_reset();
        for (int led = 0; led < 8; led++) begin
            pulse_frame();
            shift_bits(24, got, pulses);
            total_cnt++;
            if (got !== tbl[led]) begin
                $display("FAIL serial_led%0d got=%h exp=%h", led, got, tbl[led]);
            end else pass_cnt++;
        end
        fr[0] = 24'h0F0F0F;
        pulse_frame();
        total_cnt++;
        if (frame_to_transmit_dbg !== 24'h0F0F0F || no_of_frame_dbg !== 3'd0) begin
            $display("FAIL reload_after_wrap got=%h idx%0d exp=0f0f0f idx0", frame_to_transmit_dbg, no_of_frame_dbg);
        end else pass_cnt++;
    endtask

    task automatic test_load_wins();
        logic [23:0] got;
        int pulses;
        do_reset();
        for (int i = 0; i < 8; i++) fr[i] = tbl[i];
        for (int led = 0; led < 2; led++) begin
            pulse_frame();
            shift_bits(24, got, pulses);
        end
        pulse_frame();
        shift_bits(5, got, pulses);
        new_frame_rqst = 1'b1;
        new_bit_rqst = 1'b1;
        @(negedge clk);
        new_frame_rqst = 1'b0;
        new_bit_rqst = 1'b0;
        total_cnt++;
        if (frame_to_transmit_dbg !== 24'h444444 || no_of_frame_dbg !== 3'd2 || all_bits_shifted !== 1'b0) begin
            $display("FAIL load_wins got=%h idx%0d abs%b exp=444444 idx2 abs0",
                     frame_to_transmit_dbg, no_of_frame_dbg, all_bits_shifted);
        end else pass_cnt++;
        shift_bits(23, got, pulses);
        total_cnt++;
        if (all_bits_shifted !== 1'b0 || no_of_frame_dbg !== 3'd2) begin
            $display("FAIL restart_count got=abs%b idx%0d exp=abs0 idx2", all_bits_shifted, no_of_frame_dbg);
        end else pass_cnt++;
        shift_bits(1, got, pulses);
        total_cnt++;
        if (all_bits_shifted !== 1'b1 || no_of_frame_dbg !== 3'd3) begin
            $display("FAIL restart_done got=abs%b idx%0d exp=abs1 idx3", all_bits_shifted, no_of_frame_dbg);
        end else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [23:0] got;
        int pulses;
        do_reset();
        for (int i = 0; i < 8; i++) fr[i] = tbl[i];
        for (int led = 0; led < 3; led++) begin
            pulse_frame();
            shift_bits(24, got, pulses);
        end
        pulse_frame();
        shift_bits(10, got, pulses);
        total_cnt++;
        if (no_of_frame_dbg !== 3'd3 || frame_to_transmit_dbg !== 24'h222000) begin
            $display("FAIL pre_reset got=%h idx%0d exp=222000 idx3", frame_to_transmit_dbg, no_of_frame_dbg);
        end else pass_cnt++;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (frame_to_transmit_dbg !== 24'h0 || no_of_frame_dbg !== 3'd0 ||
            all_bits_shifted !== 1'b1 || bit_to_transmit !== 1'b0) begin
            $display("FAIL async_reset got=%h idx%0d abs%b bit%b exp=000000 idx0 abs1 bit0",
                     frame_to_transmit_dbg, no_of_frame_dbg, all_bits_shifted, bit_to_transmit);
        end else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        fr[0] = 24'h5A5A5A;
        @(negedge clk);
        pulse_frame();
        total_cnt++;
        if (frame_to_transmit_dbg !== 24'h5A5A5A || no_of_frame_dbg !== 3'd0) begin
            $display("FAIL post_reset_load got=%h idx%0d exp=5a5a5a idx0", frame_to_transmit_dbg, no_of_frame_dbg);
        end else pass_cnt++;
    endtask

    task automatic test_frame_sampling();
        logic [23:0] a, b;
        int pulses;
        do_reset();
        fr[0] = 24'h123456;
        fr[1] = 24'hC3A50F;
        pulse_frame();
        shift_bits(24, a, pulses);
        pulse_frame();
        shift_bits(8, a, pulses);
        fr[1] = 24'h000000;
        shift_bits(16, b, pulses);
        total_cnt++;
        if ({a[7:0], b[15:0]} !== 24'hC3A50F) begin
            $display("FAIL frame_sampled got=%h exp=c3a50f", {a[7:0], b[15:0]});
        end else pass_cnt++;
    endtask

    initial begin
        rstn = 1'b0;
        new_frame_rqst = 1'b0;
        new_bit_rqst = 1'b0;
        for (int i = 0; i < 8; i++) fr[i] = 24'h0;
        @(negedge clk);
        test_reset();
        test_single_led();
        test_all_leds();
        test_load_wins();
        test_async_reset();
        test_frame_sampling();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
